// File: rtl/song_reader.sv
// Song ROM walker: fetches {note,duration} words and hands them to the note player.
// Optional SONG_READER_END_MARKER_EN: a zero duration word ends the song early.
module song_reader #(
  parameter int NOTE_BITS = 6,
  parameter int DUR_BITS  = 6,
  parameter int IDX_BITS  = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic                          reset_play,
  input  logic [1:0]                    song,
  output logic                          song_done,
  output logic [IDX_BITS+1:0]           rom_addr,
  input  logic [NOTE_BITS+DUR_BITS-1:0] rom_data,
  output logic [NOTE_BITS-1:0]          note,
  output logic [DUR_BITS-1:0]           duration,
  output logic                          new_note,
  input  logic                          note_done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_ROM, ISSUE, WAIT_NOTE, ADVANCE, DONE
  } state_t;

  state_t state, state_nx;
  logic [IDX_BITS-1:0] index;
  logic [1:0] song_q;
  logic last;
  logic marker;
  logic restart;

  assign last    = &index;
  assign restart = reset | reset_play;

`ifdef SONG_READER_END_MARKER_EN
  assign marker = (rom_data[DUR_BITS-1:0] == '0);
`else
  assign marker = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    song_done = 1'b0;
    unique case (state)
      IDLE:      if (play) state_nx = FETCH;
      FETCH:     state_nx = WAIT_ROM;
      WAIT_ROM:  state_nx = ISSUE;
      ISSUE: begin
        if (marker) begin
          state_nx  = DONE;
          song_done = 1'b1;
        end else begin
          state_nx = WAIT_NOTE;
        end
      end
      WAIT_NOTE: if (note_done) state_nx = ADVANCE;
      ADVANCE: begin
        if (last) begin
          state_nx  = DONE;
          song_done = 1'b1;
        end else if (play) begin
          state_nx = FETCH;
        end else begin
          state_nx = IDLE;
        end
      end
      DONE:      state_nx = DONE;
      default:   state_nx = IDLE;
    endcase
    // a restart in the same cycle must never look like a song end
    if (restart) begin
      state_nx  = IDLE;
      song_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state    <= IDLE;
      index    <= '0;
      song_q   <= reset ? 2'b00 : song;
      rom_addr <= '0;
      note     <= '0;
      duration <= '0;
      new_note <= 1'b0;
    end else begin
      state    <= state_nx;
      new_note <= 1'b0;
      unique case (state)
        IDLE:    if (index == '0) song_q <= song;
        FETCH:   rom_addr <= {song_q, index};
        ISSUE: begin
          if (!marker) begin
            {note, duration} <= rom_data;
            new_note         <= 1'b1;
          end
        end
        ADVANCE: index <= last ? '0 : index + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: cycle table for the first note, then song-level
// transaction checks against the ROM contents and the latency rules.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset, play, reset_play, note_done;
  logic [1:0]  song;
  logic        song_done, new_note;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note, duration;

  logic [11:0] rom [128];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  song_reader dut (
    .clk(clk), .reset(reset), .play(play), .reset_play(reset_play),
    .song(song), .song_done(song_done), .rom_addr(rom_addr),
    .rom_data(rom_data), .note(note), .duration(duration),
    .new_note(new_note), .note_done(note_done)
  );

  typedef struct {
    logic       rst, ply, rp, nd;
    logic [1:0] sng;
    logic       nn, sd;
    logic [6:0] addr;
    logic [5:0] nt, dr;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic quiet(input int n, input bit toggle);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (toggle) note_done = (i == 1);
      @(negedge clk);
      if (new_note || song_done) bad = 1'b1;
    end
    note_done = 1'b0;
    chk("quiet", 32'(bad), 32'(0));
  endtask

  task automatic pulse_done();
    note_done = 1'b1;
    @(negedge clk);
    note_done = 1'b0;
  endtask

  task automatic wait_note(input int lat, input logic [1:0] s, input int idx);
    int n;
    logic sd;
    logic [6:0] a;
    n  = 0;
    sd = 1'b0;
    a  = {s, 5'(idx)};
    for (int i = 1; i <= lat + 3 && n == 0; i++) begin
      @(negedge clk);
      if (song_done) sd = 1'b1;
      if (new_note) n = i;
    end
    chk($sformatf("latency s%0d i%0d", s, idx), 32'(n), 32'(lat));
    chk($sformatf("song_done_low s%0d i%0d", s, idx), 32'(sd), 32'(0));
    chk($sformatf("rom_addr s%0d i%0d", s, idx), 32'(rom_addr), 32'(a));
    chk($sformatf("note s%0d i%0d", s, idx), 32'(note), 32'(rom[a][11:6]));
    chk($sformatf("duration s%0d i%0d", s, idx), 32'(duration),
        32'(rom[a][5:0]));
  endtask

  task automatic wait_marker(input int lat);
    int n;
    logic nn;
    logic [11:0] prev;
    n    = 0;
    nn   = 1'b0;
    prev = {note, duration};
    for (int i = 1; i <= lat + 2; i++) begin
      @(negedge clk);
      if (new_note) nn = 1'b1;
      if (song_done && n == 0) n = i;
    end
    chk("marker_done", 32'(n), 32'(lat - 1));
    chk("marker_no_note", 32'(nn), 32'(0));
    chk("marker_hold", 32'({note, duration}), 32'(prev));
  endtask

  // dly < 0: random note_done delay; drop_at: note where play drops;
  // stop_at: return while that note is still playing
  task automatic run_song(input logic [1:0] s, input int dly,
                          input int drop_at, input int stop_at);
    int lat;
    int d;
    play       = 1'b0;
    reset_play = 1'b1;
    song       = s;
    @(negedge clk);
    reset_play = 1'b0;
    play       = 1'b1;
    lat        = 4;
    for (int idx = 0; idx < 32; idx++) begin
`ifdef SONG_READER_END_MARKER_EN
      if (rom[{s, 5'(idx)}][5:0] == 6'd0) begin
        wait_marker(lat);
        quiet(4, 1'b1);
        return;
      end
`endif
      wait_note(lat, s, idx);
      if (idx == stop_at) return;
      d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
      if (d > 0) quiet(d, 1'b0);
      if (idx == drop_at) play = 1'b0;
      pulse_done();
      if (idx == 31) begin
        chk($sformatf("song_done_end s%0d", s), 32'(song_done), 32'(1));
        @(negedge clk);
        quiet(6, 1'b1);
        return;
      end
      chk($sformatf("song_done_mid s%0d i%0d", s, idx), 32'(song_done),
          32'(0));
      if (idx == drop_at) begin
        quiet(3, 1'b0);
        play = 1'b1;
      end
      lat = 4;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      rom[i] = 12'($urandom);
      if (rom[i][5:0] == 6'd0) rom[i][5:0] = 6'd1;
    end
    rom[7'h40] = {6'd17, 6'd8};
    rom[7'h63] = {6'd33, 6'd0};

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 7'h00, 6'd0, 6'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 7'h00, 6'd0, 6'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 7'h40, 6'd0, 6'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 7'h40, 6'd0, 6'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 7'h40, 6'd17, 6'd8};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 7'h40, 6'd17, 6'd8};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 7'h40, 6'd17, 6'd8};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 7'h40, 6'd17, 6'd8};

    reset      = 1'b1;
    play       = 1'b0;
    reset_play = 1'b0;
    note_done  = 1'b0;
    song       = 2'd0;
    @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      reset      = tbl[r].rst;
      play       = tbl[r].ply;
      reset_play = tbl[r].rp;
      note_done  = tbl[r].nd;
      song       = tbl[r].sng;
      @(negedge clk);
      chk($sformatf("tbl%0d new_note", r), 32'(new_note), 32'(tbl[r].nn));
      chk($sformatf("tbl%0d song_done", r), 32'(song_done), 32'(tbl[r].sd));
      chk($sformatf("tbl%0d rom_addr", r), 32'(rom_addr), 32'(tbl[r].addr));
      chk($sformatf("tbl%0d note", r), 32'(note), 32'(tbl[r].nt));
      chk($sformatf("tbl%0d duration", r), 32'(duration), 32'(tbl[r].dr));
    end

    // full song, fixed note_done delay
    run_song(2'd2, 2, -1, -1);

    // play drops while note 5 plays
    run_song(2'd1, -1, 5, -1);

    // reset_play collides with note_done at note 10, song switched to 1
    run_song(2'd0, -1, -1, 10);
    quiet(2, 1'b0);
    song       = 2'd1;
    note_done  = 1'b1;
    reset_play = 1'b1;
    @(negedge clk);
    note_done  = 1'b0;
    reset_play = 1'b0;
    chk("abort_no_done", 32'(song_done), 32'(0));
    wait_note(4, 2'd1, 0);

    // reset while a note plays
    run_song(2'd0, 1, -1, 7);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_outs", 32'({new_note, song_done, note, duration, rom_addr}),
        32'(0));
    reset = 1'b0;
    play  = 1'b0;
    quiet(4, 1'b1);
    song = 2'd1;
    play = 1'b1;
    wait_note(4, 2'd1, 0);

    // song 3 carries a zero duration word at note 3
    run_song(2'd3, 0, -1, -1);

    // randomized songs, delays and pause points
    for (int k = 0; k < 4; k++) begin
      run_song(2'($urandom_range(0, 3)), -1,
               $urandom_range(0, 1) ? int'($urandom_range(0, 31)) : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
